// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory subsystem: default bus widths and
// the read-response owner encoding used by the memory arbiter.
package cpu_mem_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } resp_owner_t;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// load/store. Data wins ties, but a streak counter hands the memory to fetch
// after MAX_D_STREAK consecutive data grants taken while fetch was waiting.
// Read data returns one cycle after the grant and is steered to its issuer.
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = CPU_ADDR_W,
  parameter int DATA_W       = CPU_DATA_W,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  resp_owner_t         resp_owner_q, resp_owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  // Grant decision: data first unless fetch has waited through a full streak.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (d_req && !(if_req && (streak_q == STREAK_MAX))) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Memory command mux; fetch is always a full-word read.
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = if_gnt ? if_addr : d_addr;
    mem_wdata = if_gnt ? '0 : d_wdata;
    mem_be    = if_gnt ? '1 : d_be;
  end

  // Next owner of the read data and next streak length.
  always_comb begin
    resp_owner_d = OWN_NONE;
    if (if_gnt) begin
      resp_owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      resp_owner_d = OWN_D;
    end

    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_owner_q <= OWN_NONE;
      streak_q     <= '0;
    end else begin
      resp_owner_q <= resp_owner_d;
      streak_q     <= streak_d;
    end
  end

  // Response valids are masked during reset so a read granted just before
  // reset is never acknowledged.
  assign if_rvalid = !rst && (resp_owner_q == OWN_IF);
  assign d_rvalid  = !rst && (resp_owner_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed vector table, hand-built
// starvation and reset sequences, then randomized traffic against a
// behavioural model (streak length, pending read owner, reference memory).
module tb_cpu_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = 4'hF;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT, 256 words.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:255];
  int          m_streak = 0;   // data grants taken while fetch kept waiting
  int          m_owner  = 0;   // 0 none, 1 fetch, 2 load
  logic [31:0] m_rdata  = '0;
  logic        g_if, g_d;      // grants observed in the last step

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: inputs are already driven; check against model, advance model.
  task automatic step();
    logic ed, ei, eiv, edv;
    #2;
    ed  = !rst && d_req && !(if_req && (m_streak == MAXS));
    ei  = !rst && if_req && !ed;
    eiv = !rst && (m_owner == 1);
    edv = !rst && (m_owner == 2);
    check("m_d_gnt", d_gnt, ed);
    check("m_if_gnt", if_gnt, ei);
    check("m_mem_en", mem_en, ed | ei);
    check("m_mem_we", mem_we, ed & d_we);
    if (ei) begin
      check("m_addr_if", mem_addr, if_addr);
      check("m_be_if", mem_be, 4'hF);
    end
    if (ed) begin
      check("m_addr_d", mem_addr, d_addr);
      check("m_be_d", mem_be, d_be);
      if (d_we) check("m_wdata", mem_wdata, d_wdata);
    end
    check("m_if_rvalid", if_rvalid, eiv);
    check("m_d_rvalid", d_rvalid, edv);
    if (eiv) check("m_if_rdata", if_rdata, m_rdata);
    if (edv) check("m_d_rdata", d_rdata, m_rdata);
    g_if = if_gnt;
    g_d  = d_gnt;
    if (rst) begin
      m_owner  = 0;
      m_streak = 0;
    end else begin
      m_owner = ei ? 1 : ((ed && !d_we) ? 2 : 0);
      if (ei) m_rdata = ref_mem[if_addr[9:2]];
      else if (ed && !d_we) m_rdata = ref_mem[d_addr[9:2]];
      if (ed && d_we)
        for (int b = 0; b < 4; b++)
          if (d_be[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
      m_streak = (ed && if_req) ? m_streak + 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [3:0] db);
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_be = db;
  endtask

  typedef struct {
    logic        rst, ireq;
    logic [31:0] iaddr;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dbe;
    logic        eig, edg, eiv, edv, ewe;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(logic r, logic ir, logic [31:0] ia, logic dr,
                              logic dw, logic [31:0] da, logic [31:0] dwd,
                              logic [3:0] db, logic eig, logic edg, logic eiv,
                              logic edv, logic ewe, logic [31:0] erd);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw;
    v.daddr = da; v.dwdata = dwd; v.dbe = db; v.eig = eig; v.edg = edg;
    v.eiv = eiv; v.edv = edv; v.ewe = ewe; v.erd = erd;
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[64]  = 32'hDEADBEEF; ref_mem[64]  = 32'hDEADBEEF;  // 0x100
    mem[128] = 32'hCAFEF00D; ref_mem[128] = 32'hCAFEF00D;  // 0x200

    //            rst ir iaddr    dr dw daddr    dwdata        be     ig dg iv dv we rdata
    vecs[0]  = mk(1, 1, 32'h100, 1, 0, 32'h200, 32'h0,        4'hF,  0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 32'h100, 1, 0, 32'h200, 32'h0,        4'hF,  0, 0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 1, 32'h100, 1, 0, 32'h200, 32'h0,        4'hF,  0, 1, 0, 0, 0, 32'h0);
    vecs[3]  = mk(0, 1, 32'h100, 0, 0, 32'h0,   32'h0,        4'hF,  1, 0, 0, 1, 0, 32'hCAFEF00D);
    vecs[4]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'hF,  0, 0, 1, 0, 0, 32'hDEADBEEF);
    vecs[5]  = mk(0, 0, 32'h0,   1, 1, 32'h40,  32'h12345678, 4'hF,  0, 1, 0, 0, 1, 32'h0);
    vecs[6]  = mk(0, 0, 32'h0,   1, 0, 32'h40,  32'h0,        4'hF,  0, 1, 0, 0, 0, 32'h0);
    vecs[7]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'hF,  0, 0, 0, 1, 0, 32'h12345678);
    vecs[8]  = mk(0, 1, 32'h100, 0, 0, 32'h0,   32'h0,        4'hF,  1, 0, 0, 0, 0, 32'h0);
    vecs[9]  = mk(0, 0, 32'h0,   1, 0, 32'h40,  32'h0,        4'hF,  0, 1, 1, 0, 0, 32'hDEADBEEF);
    vecs[10] = mk(0, 1, 32'h100, 0, 0, 32'h0,   32'h0,        4'hF,  1, 0, 0, 1, 0, 32'h12345678);
    vecs[11] = mk(0, 0, 32'h0,   1, 0, 32'h40,  32'h0,        4'hF,  0, 1, 1, 0, 0, 32'hDEADBEEF);
    vecs[12] = mk(0, 0, 32'h0,   1, 1, 32'h40,  32'hAABBCCDD, 4'h5,  0, 1, 0, 1, 1, 32'h12345678);
    vecs[13] = mk(0, 0, 32'h0,   1, 0, 32'h40,  32'h0,        4'hF,  0, 1, 0, 0, 0, 32'h0);
    vecs[14] = mk(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'hF,  0, 0, 0, 1, 0, 32'h12BB56DD);
    vecs[15] = mk(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'hF,  0, 0, 0, 0, 0, 32'h0);

    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
            vecs[i].daddr, vecs[i].dwdata, vecs[i].dbe);
      #1;
      check("t_if_gnt", if_gnt, vecs[i].eig);
      check("t_d_gnt", d_gnt, vecs[i].edg);
      check("t_mem_en", mem_en, vecs[i].eig | vecs[i].edg);
      check("t_mem_we", mem_we, vecs[i].ewe);
      check("t_if_rvalid", if_rvalid, vecs[i].eiv);
      check("t_d_rvalid", d_rvalid, vecs[i].edv);
      if (vecs[i].eiv) check("t_if_rdata", if_rdata, vecs[i].erd);
      if (vecs[i].edv) check("t_d_rdata", d_rdata, vecs[i].erd);
      $display("vec %0d: if_gnt=%b d_gnt=%b mem_we=%b if_rvalid=%b d_rvalid=%b rdata=%h",
               i, if_gnt, d_gnt, mem_we, if_rvalid, d_rvalid, mem_rdata);
      step();
    end

    // Starvation: both ports held high -> D D D D F repeating.
    for (int k = 0; k < 15; k++) begin
      drive(0, 1, 32'h100, 1, 0, 32'h40, 32'h0, 4'hF);
      #1;
      check("starve_d_gnt", d_gnt, (k % 5) < 4);
      check("starve_if_gnt", if_gnt, (k % 5) == 4);
      $display("starve %0d: d_gnt=%b if_gnt=%b", k, d_gnt, if_gnt);
      step();
    end
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'hF);
    step();

    // Reset the cycle after a fetch grant: no if_rvalid.
    drive(0, 1, 32'h100, 0, 0, 32'h0, 32'h0, 4'hF);
    #1;
    check("rmid_if_gnt", if_gnt, 1'b1);
    step();
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'hF);
    #1;
    check("rmid_if_rvalid", if_rvalid, 1'b0);
    $display("reset after fetch grant: if_rvalid=%b", if_rvalid);
    step();

    // Partial streak, reset after a load grant, streak must restart at 0.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h100, 1, 0, 32'h40, 32'h0, 4'hF);
      step();
    end
    drive(1, 1, 32'h100, 1, 0, 32'h40, 32'h0, 4'hF);
    #1;
    check("rmid_d_rvalid", d_rvalid, 1'b0);
    check("rmid_no_gnt", {if_gnt, d_gnt, mem_en}, 3'b000);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 32'h100, 1, 0, 32'h40, 32'h0, 4'hF);
      #1;
      check("rst_streak_d_gnt", d_gnt, k < 4);
      $display("post-reset %0d: d_gnt=%b if_gnt=%b", k, d_gnt, if_gnt);
      step();
    end
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'hF);
    step();

    // Randomized traffic obeying the hold-until-grant rule.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!if_req && $urandom_range(0, 99) < 60) begin
        if_req  = 1'b1;
        if_addr = 32'($urandom_range(0, 31)) << 2;
      end
      if (!d_req && $urandom_range(0, 99) < 60) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 31)) << 2;
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(0, 15));
      end
      step();
      if (g_if) if_req = 1'b0;
      if (g_d)  d_req  = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Arbitrates the CPU's single-port synchronous memory between the instruction-fetch port and the load/store port. Each cycle it grants at most one requester and drives the memory command. It routes the read data returned one cycle later back to the requester that issued the access. The data port has priority, bounded by an anti-starvation streak limit so fetch always makes progress. Sits between the `cpu` core and its unified memory.

## Interface
- `ADDR_W`, 32, address width for both ports and memory.
- `DATA_W`, 32, data width; a multiple of 8.
- `MAX_D_STREAK`, 4, maximum consecutive data grants while fetch waits; ≥1.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted this cycle
- `if_rvalid`  out  1  fetch data valid
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  load/store request
- `d_we`  in  1  1 = store
- `d_addr`  in  ADDR_W  load/store address
- `d_wdata`  in  DATA_W  store data
- `d_be`  in  DATA_W/8  store byte enables
- `d_gnt`  out  1  load/store accepted this cycle
- `d_rvalid`  out  1  load data valid (loads only)
- `d_rdata`  out  DATA_W  load read data
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  1  memory write
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_be`  out  DATA_W/8  memory byte enables
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after a read

## Operation
- Requester rule: hold `req` and all command fields stable until `gnt` is seen high. The command is consumed in the `gnt` cycle. A new request may be presented the next cycle.
- Grant decision is combinational in cycle t:
  - `d_req` only: grant data.
  - `if_req` only: grant fetch.
  - Both high: grant data unless `streak == MAX_D_STREAK`, in which case grant fetch.
  - Neither high: no grant.
- Memory command in cycle t:
  - `mem_en = if_gnt | d_gnt`.
  - `mem_we = d_gnt & d_we`.
  - `mem_addr`, `mem_wdata` and `mem_be` select the fetch port when `if_gnt`, otherwise the data port.
  - Fetch accesses force `mem_be` to all ones and `mem_we` to 0.
- Response routing:
  - Register `resp_owner` ∈ {NONE, IF, D} captures the read owner at each edge: IF on a fetch grant, D on a load grant, NONE otherwise (including stores).
  - `if_rvalid = (resp_owner == IF)`; `d_rvalid = (resp_owner == D)`.
  - `if_rdata` and `d_rdata` both equal `mem_rdata` unconditionally; the data is meaningful only when the matching `rvalid` is high.
- Streak counter, width $clog2(MAX_D_STREAK+1):
  - Increments on a data grant while `if_req` is high.
  - Clears on any fetch grant, and on any cycle with `if_req` low.
  - Never exceeds `MAX_D_STREAK`.

## Timing
- Grant latency is 0 cycles, combinational from `req`. Read latency is 1 cycle from grant to `rvalid`. Throughput is one access per cycle, with back-to-back grants allowed to either port.
- Reset values:
  - `resp_owner = NONE`, `streak = 0`.
  - `if_rvalid = d_rvalid = 0`.
- While `rst` is high:
  - `if_gnt = d_gnt = 0`.
  - `mem_en = mem_we = 0`.
- Reset mid-operation: a read granted in the cycle before `rst` is asserted produces no `rvalid`. No other access is issued or acknowledged while `rst` is high.
- No-grant cycle: `mem_en = 0`, `mem_we = 0`. Address and data outputs follow the data port and are don't-care.
- Stores: `d_gnt` completes the write; no `d_rvalid` follows.
- At most one `gnt` and at most one `rvalid` are high in any cycle.

## Structure
- Shared package `cpu_mem_pkg` holds:
  - the `resp_owner_t` enum (OWN_NONE, OWN_IF, OWN_D);
  - default `ADDR_W` and `DATA_W` constants, used by `cpu` as well.
- Single module with no sub-modules: grant logic, a two-bit owner register and the streak counter.

## Test plan
- Reset: hold `rst` 2 cycles with both requests high. Required: no `gnt`, `mem_en = 0`, no `rvalid`. After release, the first grant goes to data.
- Fetch only: `if_req` with `if_addr` = 0x100, memory returns 0xDEADBEEF. Required: `if_gnt` and `mem_en` in the same cycle; `if_rvalid` with `if_rdata` = 0xDEADBEEF exactly one cycle later.
- Store then load: store 0x12345678 to 0x40 with `d_be` = 0xF, then load from 0x40. Required: `mem_we = 1` on the store only; no `d_rvalid` for the store; `d_rvalid` with 0x12345678 one cycle after the load grant.
- Starvation: `if_req` and `d_req` held high continuously. Required: exactly 4 data grants, then 1 fetch grant, repeating.
- Reset mid-read: assert `rst` the cycle after a fetch grant. Required: `if_rvalid` stays 0 and `streak` returns to 0.
- Back-to-back: alternating single-cycle requests from each port. Required: a grant every cycle and `rvalid` routed to the correct port each following cycle.
